// File: rtl/ddr3_bank_scheduler.sv
// Multi-bank DDR3 command sequencer: open-row tracking, PRE/ACT/RD/WR/REF with tRCD/tRP/tRFC spacing.
// Optional DDR3_AUTO_REFRESH_EN adds an internal T_REFI interval counter feeding the refresh request.
module ddr3_bank_scheduler #(
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned ROW_W     = 15,
    parameter int unsigned COL_W     = 10,
    parameter int unsigned T_RCD     = 5,
    parameter int unsigned T_RP      = 5,
    parameter int unsigned T_RFC     = 10,
    parameter int unsigned T_REFI    = 780,
    localparam int unsigned BA_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [BA_W-1:0]      req_bank_i,
    input  logic [ROW_W-1:0]     req_row_i,
    input  logic [COL_W-1:0]     req_col_i,
    input  logic                 ref_req_i,
    output logic                 ref_ack_o,
    output logic                 cs_o,
    output logic                 ras_o,
    output logic                 cas_o,
    output logic                 we_o,
    output logic [ROW_W-1:0]     addr_o,
    output logic [BA_W-1:0]      ba_o,
    output logic                 cmd_rd_o,
    output logic                 cmd_wr_o,
    output logic [NUM_BANKS-1:0] bank_open_o
);

    localparam int unsigned CNT_W = 16;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    if ((T_RCD < 1) || (T_RP < 1) || (T_RFC < 1) || (T_REFI < 1) || (ROW_W < 11) || (COL_W > 10)) begin : g_param_check
        $error("ddr3_bank_scheduler: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD,
        S_RDWR, S_PREALL, S_WAIT_RPA, S_REF, S_WAIT_RFC
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [ROW_W-1:0]     addr_q, addr_d;
    logic [BA_W-1:0]      ba_q, ba_d;
    logic                 ref_ack_q, ref_ack_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [NUM_BANKS-1:0] open_q, open_d;
    logic [ROW_W-1:0]     row_q [NUM_BANKS];
    logic [ROW_W-1:0]     row_d [NUM_BANKS];
    logic                 ref_pend_q, ref_pend_d;
    logic                 wr_req_q, wr_req_d;
    logic [BA_W-1:0]      bank_q, bank_d;
    logic [ROW_W-1:0]     rrow_q, rrow_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 do_act, do_rw, do_ref;
    logic                 refi_hit;

    // Next state and registered pin values; WAIT_* states issue their follow-on command on the zero count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        cmd_d     = CMD_NOP;
        addr_d    = '0;
        ba_d      = '0;
        ref_ack_d = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        open_d    = open_q;
        row_d     = row_q;
        wr_req_d  = wr_req_q;
        bank_d    = bank_q;
        rrow_d    = rrow_q;
        col_d     = col_q;
        do_act    = 1'b0;
        do_rw     = 1'b0;
        do_ref    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ref_pend_q) begin
                    state_d = (|open_q) ? S_PREALL : S_REF;
                end else if (req_valid_i) begin
                    wr_req_d = req_write_i;
                    bank_d   = req_bank_i;
                    rrow_d   = req_row_i;
                    col_d    = req_col_i;
                    if (open_q[req_bank_i] && (row_q[req_bank_i] == req_row_i)) begin
                        state_d = S_RDWR;
                    end else if (open_q[req_bank_i]) begin
                        state_d = S_PRE;
                    end else begin
                        state_d = S_ACT;
                    end
                end
            end
            S_PRE: begin
                cmd_d          = CMD_PRE;
                ba_d           = bank_q;
                open_d[bank_q] = 1'b0;
                cnt_d          = CNT_W'(T_RP - 1);
                state_d        = S_WAIT_RP;
            end
            S_WAIT_RP:  do_act = (cnt_q == '0);
            S_ACT:      do_act = 1'b1;
            S_WAIT_RCD: do_rw  = (cnt_q == '0);
            S_RDWR:     do_rw  = 1'b1;
            S_PREALL: begin
                cmd_d      = CMD_PRE;
                addr_d[10] = 1'b1;
                open_d     = '0;
                cnt_d      = CNT_W'(T_RP - 1);
                state_d    = S_WAIT_RPA;
            end
            S_WAIT_RPA: do_ref = (cnt_q == '0);
            S_REF:      do_ref = 1'b1;
            S_WAIT_RFC: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_act) begin
            cmd_d          = CMD_ACT;
            addr_d         = rrow_q;
            ba_d           = bank_q;
            open_d[bank_q] = 1'b1;
            row_d[bank_q]  = rrow_q;
            cnt_d          = CNT_W'(T_RCD - 1);
            state_d        = S_WAIT_RCD;
        end
        if (do_rw) begin
            cmd_d   = wr_req_q ? CMD_WR : CMD_RD;
            addr_d  = ROW_W'(col_q);
            ba_d    = bank_q;
            rd_d    = !wr_req_q;
            wr_d    = wr_req_q;
            state_d = S_IDLE;
        end
        if (do_ref) begin
            cmd_d     = CMD_REF;
            ref_ack_d = 1'b1;
            cnt_d     = CNT_W'(T_RFC - 1);
            state_d   = S_WAIT_RFC;
        end

        // Requests arriving while a refresh is already pending are absorbed.
        ref_pend_d = do_ref ? 1'b0 : (ref_pend_q | ref_req_i | refi_hit);
    end

`ifdef DDR3_AUTO_REFRESH_EN
    logic [CNT_W-1:0] refi_q, refi_d;

    // Refresh interval timer, restarted whenever a REF goes out.
    always_comb begin
        refi_d = refi_q;
        if (do_ref) begin
            refi_d = CNT_W'(T_REFI);
        end else if (refi_q != '0) begin
            refi_d = refi_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            refi_q <= CNT_W'(T_REFI);
        end else begin
            refi_q <= refi_d;
        end
    end

    assign refi_hit = (refi_q == '0);
`else
    assign refi_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cmd_q      <= CMD_NOP;
            addr_q     <= '0;
            ba_q       <= '0;
            ref_ack_q  <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            open_q     <= '0;
            row_q      <= '{default: '0};
            ref_pend_q <= 1'b0;
            wr_req_q   <= 1'b0;
            bank_q     <= '0;
            rrow_q     <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            ba_q       <= ba_d;
            ref_ack_q  <= ref_ack_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            open_q     <= open_d;
            row_q      <= row_d;
            ref_pend_q <= ref_pend_d;
            wr_req_q   <= wr_req_d;
            bank_q     <= bank_d;
            rrow_q     <= rrow_d;
            col_q      <= col_d;
        end
    end

    assign req_ready_o              = rst_ni && (state_q == S_IDLE) && !ref_pend_q;
    assign {cs_o, ras_o, cas_o, we_o} = cmd_q;
    assign addr_o                   = addr_q;
    assign ba_o                     = ba_q;
    assign ref_ack_o                = ref_ack_q;
    assign cmd_rd_o                 = rd_q;
    assign cmd_wr_o                 = wr_q;
    assign bank_open_o              = open_q;

endmodule
